gray_sevenseg_scan: RTL and testbench

//  Downstream consumer of the N-bit Gray counter. Registers the Gray code on each enable pulse and converts it to binary.

---
 rtl/gray_disp_pkg.sv | 19 +
 rtl/seg_scan_timer.sv | 23 ++
 rtl/gray_sevenseg_scan.sv | 56 +++++
 tb/tb_gray_sevenseg_scan.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/gray_disp_pkg.sv
// gray_disp_pkg: hex font and Gray/popcount helpers shared by the Gray display slice
package gray_disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: refresh prescaler and digit index for a multiplexed display
module seg_scan_timer #(
  parameter int REFRESH = 100000,
  parameter int DIGITS = 4,
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          tick,
  output logic [IW-1:0] idx
);
  localparam int PW = REFRESH > 1 ? $clog2(REFRESH) : 1;
  logic [PW-1:0] cnt;
  assign tick = cnt == PW'(REFRESH - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      idx <= IW'(DIGITS - 1);
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/gray_sevenseg_scan.sv
// gray_sevenseg_scan: samples a Gray counter, flags illegal steps, scans the value as hex digits
module gray_sevenseg_scan import gray_disp_pkg::*; #(
  parameter int N = 8,
  parameter int DIGITS = 4,
  parameter int REFRESH = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      gray_in,
  input  logic              gray_valid,
  input  logic              err_clr,
  output logic [N-1:0]      bin_out,
  output logic              step_err,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [N-1:0] gray_q;
  logic have_prev, tick, err, blank;
  logic [IW-1:0] idx, nidx;
  logic [W-1:0] ext, hi;
  logic [3:0] nib;
  seg_scan_timer #(.REFRESH(REFRESH), .DIGITS(DIGITS)) u_timer (
    .clk(clk), .reset(reset), .tick(tick), .idx(idx));
  // display loads the digit being switched to, so decode from the next index
  assign nidx = idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
  assign ext = W'(bin_out);
  assign hi = ext >> {nidx, 2'b00};
  assign nib = hi[3:0];
  assign blank = BLANK_LZ != 0 && nidx != '0 && hi == '0;
  assign err = gray_valid && have_prev && popcount(32'(gray_in ^ gray_q)) != 6'd1;
  assign dp = 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      gray_q <= '0;
      bin_out <= '0;
      have_prev <= 1'b0;
      step_err <= 1'b0;
      an <= '1;
      seg <= SEG_BLANK;
    end else begin
      if (gray_valid) begin
        gray_q <= gray_in;
        bin_out <= N'(gray2bin(32'(gray_in)));
        have_prev <= 1'b1;
      end
      step_err <= err | (step_err & ~err_clr);
      if (tick) begin
        an <= ~(DIGITS'(1) << nidx);
        seg <= blank ? SEG_BLANK : SEG_FONT[nib];
      end
    end
endmodule

// File: tb/tb_gray_sevenseg_scan.sv
// tb_gray_sevenseg_scan: scoreboard bench for two display variants (leading-zero blanking on/off)
module tb_gray_sevenseg_scan;
  localparam int N = 8, D = 4, R = 4;
  typedef struct { logic [7:0] bin; logic err; } exp_t;
  logic clk = 0, reset = 0;
  logic [7:0] gray_in = '0;
  logic gray_valid = 0, err_clr = 0;
  logic [7:0] bin1, bin0;
  logic se1, se0, dp1, dp0;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [7:0] mprev = '0, sbin = '0;
  bit have = 0, sticky = 0;
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;
  gray_sevenseg_scan #(.N(N), .DIGITS(D), .REFRESH(R), .BLANK_LZ(1)) dut1 (
    .clk(clk), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid), .err_clr(err_clr),
    .bin_out(bin1), .step_err(se1), .an(an1), .seg(seg1), .dp(dp1));
  gray_sevenseg_scan #(.N(N), .DIGITS(D), .REFRESH(R), .BLANK_LZ(0)) dut0 (
    .clk(clk), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid), .err_clr(err_clr),
    .bin_out(bin0), .step_err(se0), .an(an0), .seg(seg0), .dp(dp0));
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] seg_of(logic [7:0] b, int k, bit lz);
    int v;
    v = int'(b) >> (4 * k);
    if (lz && k > 0 && v == 0) return 7'h7F;
    return font[v & 15];
  endfunction
  // binary value is the counter position whose Gray code matches
  function automatic logic [7:0] g2b(logic [7:0] g);
    for (int i = 0; i < 256; i++) if (8'(i ^ (i >> 1)) == g) return 8'(i);
    return 8'h00;
  endfunction
  task automatic drive(bit v, logic [7:0] g, bit c);
    bit e;
    @(negedge clk);
    gray_valid = v; gray_in = g; err_clr = c;
    e = 0;
    if (v) begin
      e = have && $countones(g ^ mprev) != 1;
      mprev = g; have = 1; sbin = g2b(g);
    end
    sticky = e ? 1'b1 : (c ? 1'b0 : sticky);
    if (v || c) q.push_back('{sbin, sticky});
  endtask
  task automatic idle(int n);
    repeat (n) drive(0, 8'h00, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 0; gray_valid = 0; err_clr = 0;
    have = 0; sticky = 0; sbin = '0; mprev = '0;
    repeat (3) @(negedge clk);
    reset = 1;
  endtask
  initial begin : mon
    int cyc, ridx;
    logic [7:0] mb;
    logic mst;
    logic [3:0] ean;
    logic [6:0] es1, es0;
    bit fired;
    exp_t e;
    cyc = 0; ridx = D - 1; mb = '0; mst = 0; ean = 4'hF; es1 = 7'h7F; es0 = 7'h7F;
    forever begin
      @(posedge clk);
      fired = reset && (gray_valid || err_clr);
      if (!reset) begin
        cyc = 0; ridx = D - 1; mb = '0; mst = 0; ean = 4'hF; es1 = 7'h7F; es0 = 7'h7F;
      end else begin
        cyc++;
        if (cyc == R) begin
          cyc = 0;
          ridx = (ridx + 1) % D;
          ean = ~(4'b1 << ridx);
          es1 = seg_of(mb, ridx, 1);
          es0 = seg_of(mb, ridx, 0);
        end
      end
      #1;
      if (fired) begin
        if (q.size() == 0) chk("queue_underflow", 1, 0);
        else begin
          e = q.pop_front();
          mb = e.bin; mst = e.err;
        end
      end
      chk("bin_out_lz1", bin1, mb);
      chk("bin_out_lz0", bin0, mb);
      chk("step_err_lz1", se1, mst);
      chk("step_err_lz0", se0, mst);
      chk("an_lz1", an1, ean);
      chk("an_lz0", an0, ean);
      chk("seg_lz1", seg1, es1);
      chk("seg_lz0", seg0, es0);
      chk("dp", {dp1, dp0}, 2'b11);
    end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1;
    idle(6);
    drive(1, 8'h03, 0); idle(20);
    drive(1, 8'h80, 0); idle(20);
    do_reset();
    drive(1, 8'h00, 0); idle(2);
    drive(1, 8'h03, 0); idle(5);
    drive(0, 8'h00, 1); idle(3);
    drive(1, 8'h03, 1); idle(3);
    drive(0, 8'h00, 1); idle(2);
    repeat (150) begin
      logic [7:0] g;
      g = ($urandom % 4 == 0) ? 8'($urandom) : mprev ^ (8'h01 << ($urandom % 8));
      drive($urandom % 4 != 0, g, $urandom % 8 == 0);
      idle($urandom_range(0, 6));
    end
    do_reset();
    for (int i = 0; i <= 256; i++) drive(1, 8'((i % 256) ^ ((i % 256) >> 1)), 0);
    idle(2);
    chk("full_run_no_err", se1, 0);
    n = 0;
    while (an1 !== 4'hB && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_an_B_timeout", n < 100, 1);
    #2 reset = 0;
    have = 0; sticky = 0; sbin = '0; mprev = '0;
    #1;
    chk("async_an", an1, 4'hF);
    chk("async_seg", seg1, 7'h7F);
    chk("async_bin", bin1, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1;
    idle(20);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
